// File: rtl/ex_pipe_stage.sv
// Handshaked pipeline stage register with flush and bubble zeroing.
// Define EX_PIPE_STAGE_SKID_EN for the two-entry skid variant with registered in_ready.
module ex_pipe_stage #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        occupancy
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic [RD_W-1:0]   m_rd;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = m_valid & out_ready;

    // Empty slots are always zeroed, so outputs can come straight from M.
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl;
    assign out_rd    = m_rd;

`ifdef EX_PIPE_STAGE_SKID_EN

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic [RD_W-1:0]   s_rd;

    // Depends only on a flop, so out_ready never reaches in_ready.
    assign in_ready  = ~s_valid;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
            m_rd    <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= '0;
            s_rd    <= '0;
        end else if (out_xfer && s_valid) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_ctrl  <= s_ctrl;
            m_rd    <= s_rd;
            if (in_xfer) begin
                s_valid <= 1'b1;
                s_data  <= in_data;
                s_ctrl  <= in_ctrl;
                s_rd    <= in_rd;
            end else begin
                s_valid <= 1'b0;
                s_data  <= '0;
                s_ctrl  <= '0;
                s_rd    <= '0;
            end
        end else if (in_xfer && (!m_valid || out_xfer)) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_ctrl  <= in_ctrl;
            m_rd    <= in_rd;
        end else if (in_xfer) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
            s_ctrl  <= in_ctrl;
            s_rd    <= in_rd;
        end else if (out_xfer) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
            m_rd    <= '0;
        end
    end

`else

    assign in_ready  = out_ready | ~m_valid;
    assign occupancy = {1'b0, m_valid};

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
            m_rd    <= '0;
        end else if (in_xfer) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_ctrl  <= in_ctrl;
            m_rd    <= in_rd;
        end else if (out_xfer) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
            m_rd    <= '0;
        end
    end

`endif

endmodule

// File: tb/tb_ex_pipe_stage.sv
// Directed vector bench for ex_pipe_stage, both with and without the skid buffer.
// Inputs change on the falling edge; outputs are checked just before the next rising edge.
module tb_ex_pipe_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [7:0]   in_ctrl;
    logic [4:0]   in_rd;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [7:0]   out_ctrl;
    logic [4:0]   out_rd;
    logic [1:0]   occupancy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_pipe_stage dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .occupancy (occupancy)
    );

    typedef struct {
        logic         rst;
        logic         fl;
        logic         iv;
        logic [127:0] d;
        logic [7:0]   c;
        logic [4:0]   rd;
        logic         ordy;
        logic         ev;
        logic [127:0] ed;
        logic [7:0]   ec;
        logic [4:0]   erd;
        logic [1:0]   eocc;
        logic         erdy;
        logic         crdy;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic ev,
                           input logic [127:0] ed, input logic [7:0] ec,
                           input logic [4:0] erd, input logic [1:0] eocc);
        chk({name, ".valid"}, 128'(out_valid), 128'(ev));
        chk({name, ".data"}, out_data, ed);
        chk({name, ".ctrl"}, 128'(out_ctrl), 128'(ec));
        chk({name, ".rd"}, 128'(out_rd), 128'(erd));
        chk({name, ".occ"}, 128'(occupancy), 128'(eocc));
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [127:0] d, input logic [7:0] c,
                         input logic [4:0] rd, input logic ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        in_rd     = rd;
        out_ready = ordy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 1);
        step();

        // rst fl iv data ctrl rd ordy | ev data ctrl rd occ rdy crdy
        vecs[0]  = '{1, 0, 1, 128'hAA, 8'hFF, 5'd3, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[1]  = '{1, 0, 1, 128'hAA, 8'hFF, 5'd3, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[2]  = '{1, 0, 1, 128'hAA, 8'hFF, 5'd3, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[3]  = '{0, 0, 1, 128'hAA, 8'hFF, 5'd3, 0, 0, 0, 0, 0, 0, 1, 1};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 1, 1, 128'hAA, 8'hFF, 5'd3, 1, 1, 1};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[6]  = '{0, 1, 1, 128'h55, 8'h04, 5'd7, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[8]  = '{0, 0, 1, 128'h11, 8'h02, 5'd1, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 128'h11, 8'h02, 5'd1, 1, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 128'h11, 8'h02, 5'd1, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 128'h11, 8'h02, 5'd1, 1, 1, 1};
        vecs[12] = '{0, 0, 1, 128'h22, 8'h08, 5'd2, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[13] = '{0, 1, 0, 0, 0, 0, 0, 1, 128'h22, 8'h08, 5'd2, 1, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d,
                  vecs[i].c, vecs[i].rd, vecs[i].ordy);
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed,
                    vecs[i].ec, vecs[i].erd, vecs[i].eocc);
            if (vecs[i].crdy)
                chk($sformatf("vec%0d.in_ready", i), 128'(in_ready),
                    128'(vecs[i].erdy));
            step();
        end

        // Streaming: 16 back-to-back entries, one-cycle latency.
        for (int k = 0; k <= 16; k++) begin
            drive(0, 0, k < 16, 128'(k), 8'(k + 1), 5'(k), 1);
            chk($sformatf("stream%0d.in_ready", k), 128'(in_ready), 128'(1));
            if (k > 0)
                chk_out($sformatf("stream%0d", k), 1, 128'(k - 1),
                        8'(k), 5'(k - 1), 1);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        chk_out("stream_end", 0, 0, 0, 0, 0);
        step();

`ifdef EX_PIPE_STAGE_SKID_EN
        // A into M, B into S, C refused.
        drive(0, 0, 1, 128'hA, 8'h01, 5'd10, 0);
        chk("skid.a_rdy", 128'(in_ready), 128'(1));
        step();
        drive(0, 0, 1, 128'hB, 8'h02, 5'd11, 0);
        chk("skid.b_rdy", 128'(in_ready), 128'(1));
        chk_out("skid.a_held", 1, 128'hA, 8'h01, 5'd10, 1);
        step();
        drive(0, 0, 1, 128'hC, 8'h03, 5'd12, 0);
        chk("skid.c_rdy", 128'(in_ready), 128'(0));
        chk_out("skid.full", 1, 128'hA, 8'h01, 5'd10, 2);
        step();
        chk("skid.c_rdy2", 128'(in_ready), 128'(0));
        chk_out("skid.full2", 1, 128'hA, 8'h01, 5'd10, 2);
        drive(0, 0, 1, 128'hC, 8'h03, 5'd12, 1);
        chk_out("skid.rel_a", 1, 128'hA, 8'h01, 5'd10, 2);
        step();
        chk("skid.rel_rdy", 128'(in_ready), 128'(1));
        chk_out("skid.rel_b", 1, 128'hB, 8'h02, 5'd11, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk_out("skid.rel_c", 1, 128'hC, 8'h03, 5'd12, 1);
        step();
        chk_out("skid.drained", 0, 0, 0, 0, 0);

        // Flush with both slots full and an input pending.
        drive(0, 0, 1, 128'hD, 8'h01, 5'd13, 0);
        step();
        drive(0, 0, 1, 128'hE, 8'h02, 5'd14, 0);
        step();
        drive(0, 1, 1, 128'h77, 8'h04, 5'd7, 0);
        chk_out("flush.pre", 1, 128'hD, 8'h01, 5'd13, 2);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk_out("flush.post", 0, 0, 0, 0, 0);
        chk("flush.rdy", 128'(in_ready), 128'(1));
        step();
        chk_out("flush.no_rd7", 0, 0, 0, 0, 0);
`else
        // Held A blocks B combinationally.
        drive(0, 0, 1, 128'hA, 8'h01, 5'd10, 0);
        step();
        drive(0, 0, 1, 128'hB, 8'h02, 5'd11, 0);
        chk("bp.rdy_low", 128'(in_ready), 128'(0));
        chk_out("bp.a_held", 1, 128'hA, 8'h01, 5'd10, 1);
        step();
        chk("bp.rdy_low2", 128'(in_ready), 128'(0));
        chk_out("bp.a_stable", 1, 128'hA, 8'h01, 5'd10, 1);
        drive(0, 0, 1, 128'hB, 8'h02, 5'd11, 1);
        chk("bp.rdy_high", 128'(in_ready), 128'(1));
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk_out("bp.b_out", 1, 128'hB, 8'h02, 5'd11, 1);
        step();
        chk_out("bp.drained", 0, 0, 0, 0, 0);

        // Flush while full with an input pending.
        drive(0, 0, 1, 128'hD, 8'h01, 5'd13, 0);
        step();
        drive(0, 1, 1, 128'h77, 8'h04, 5'd7, 0);
        chk_out("flush.pre", 1, 128'hD, 8'h01, 5'd13, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_out("flush.post", 0, 0, 0, 0, 0);
        chk("flush.rdy", 128'(in_ready), 128'(1));
        step();
        chk_out("flush.no_rd7", 0, 0, 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_pipe_stage.md
# ex_pipe_stage

Parametrised, handshaked pipeline stage register replacing fixed-field inter-stage latches such as EX→MEM. It carries an opaque data payload, a control vector and a destination register index. It adds valid/ready flow control, synchronous flush for branch squash, and guaranteed bubble zeroing of control bits. It sits between any two processor stages (ID/EX, EX/MEM, MEM/WB); an optional skid buffer registers the backpressure path.

## Interface
Parameters:
- DATA_W, 128, payload width (e.g. ALU result + store data + branch target, packed by the instantiating stage)
- CTRL_W, 8, control-bit width (MemRead, MemWrite, RegWrite, MemtoReg, BranchEq, BranchGt, Zero, Great, …)
- RD_W, 5, destination register index width

Ports (clock and reset: reset is synchronous, active-high; the clock is clk):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  squash every held entry and the current input
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage accepts the entry this cycle
- in_data  in  DATA_W  payload
- in_ctrl  in  CTRL_W  control bits
- in_rd  in  RD_W  destination register
- out_valid  out  1  entry present at output
- out_ready  in  1  downstream consumes the output this cycle
- out_data  out  DATA_W  payload
- out_ctrl  out  CTRL_W  control bits, all zero whenever out_valid=0
- out_rd  out  RD_W  destination register, zero whenever out_valid=0
- occupancy  out  2  held entries (0..1 without skid, 0..2 with skid)

## Operation
- Input transfer: in_valid & in_ready at an edge. Output transfer: out_valid & out_ready at an edge.
- Main register (M) drives the outputs. With the skid feature, skid register (S) sits behind M.
- Entries leave in arrival order. No entry is duplicated or dropped except by flush.
- Bubble rule: any register slot without a valid entry holds all-zero ctrl, rd and data. A bubble can never assert RegWrite or MemWrite downstream.
- Priority each edge: reset > flush > normal transfer.
- reset: all valid bits, data, ctrl, rd and occupancy go to 0.
- flush: at the edge it is sampled, M and S become bubbles (zeroed). An input presented in the same cycle is discarded, even if in_ready=1. An output transfer in the flush cycle still counts as consumed by downstream.
- Normal, no skid:
  - in_ready = out_ready | ~out_valid (combinational).
  - On input transfer, M loads the input.
  - On an output transfer with no input transfer, M becomes a bubble.
- Normal, skid:
  - in_ready = ~S.valid, registered with no combinational path from out_ready.
  - Input transfer when M is empty, or when M transfers out the same cycle, and S is empty: input goes to M.
  - Input transfer when M is held (valid & ~out_ready): input goes to S.
  - On an output transfer with S valid: M ← S, S ← bubble. A simultaneous input then goes to S.
- occupancy = M.valid + S.valid.

## Timing
- Latency: an accepted input appears on outputs the cycle after the accepting edge.
- Throughput: 1 entry/cycle sustained while out_ready=1, in both configurations.
- Skid: in_ready falls one cycle after S fills and rises one cycle after S drains. At most one extra entry is accepted after out_ready drops.
- Reset or flush mid-stall: out_valid=0 and in_ready=1 in the following cycle.
- Reset values: out_valid=0, out_data=0, out_ctrl=0, out_rd=0, occupancy=0, in_ready=1.

## Configuration
- EX_PIPE_STAGE_SKID_EN defined: two-entry stage (M+S), registered in_ready, occupancy max 2.
- Undefined: single register M, combinational in_ready from out_ready, S logic absent, occupancy max 1, occupancy[1] tied 0.

## Test plan
- Reset: drive in_valid=1 and in_ctrl=8'hFF with reset=1 for 3 cycles. Required: out_valid=0, out_ctrl=0, occupancy=0 throughout, and the cycle after reset=0 the entry appears.
- Streaming: 16 back-to-back entries with data=i and out_ready=1. Required: outputs data 0..15 in order, one per cycle, 1-cycle latency.
- Backpressure (skid): hold out_ready=0 while sending A, B, C. Required: A in M, B in S, C not accepted (in_ready=0), occupancy=2. Release: A, B, C appear on consecutive cycles.
- Backpressure (no skid): out_ready=0 with M holding A. Required: in_ready=0 in the same cycle and A held stable.
- Flush: with occupancy=2 and in_valid=1 carrying rd=7, ctrl=RegWrite, assert flush for one cycle. Required next cycle: out_valid=0, out_ctrl=0, out_rd=0, occupancy=0, and the rd=7 entry never appears.
- Bubble: send one entry then idle with out_ready=1. Required: the cycle after it is consumed, out_ctrl=0 and out_data=0.
